// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes follow the core's HI/LO instruction group; states follow the
// IDLE -> PREP -> RUN -> FIX -> DONE sequence of muldiv_unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Even op codes are the signed variants.
  function automatic logic op_is_signed(input logic [1:0] op_v);
    return ~op_v[0];
  endfunction

  // Upper op bit selects divide.
  function automatic logic op_is_div(input logic [1:0] op_v);
    return op_v[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath.
// Multiply: radix-2 shift-add; acc holds {partial product, remaining multiplier}.
// Divide: restoring step; acc holds {partial remainder, remaining dividend}.
// In divide mode bit 0 of acc_o is left clear; the caller merges qbit_o there.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               mode_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               qbit_o
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] rem_sh_s;
  logic [WIDTH:0] diff_s;

  // Single shift-add or trial-subtract step selected by mode.
  always_comb begin
    sum_s    = {(WIDTH+1){1'b0}};
    rem_sh_s = {(WIDTH+1){1'b0}};
    diff_s   = {(WIDTH+1){1'b0}};
    qbit_o   = 1'b0;
    acc_o    = acc_i;
    if (mode_i == MODE_MUL) begin
      sum_s = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
            + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
      acc_o = {sum_s, acc_i[WIDTH-1:1]};
    end else begin
      // Remainder shifted left with the next dividend bit; the extra top bit
      // keeps the trial subtraction exact for divisors with the MSB set.
      rem_sh_s = acc_i[2*WIDTH-1:WIDTH-1];
      diff_s   = rem_sh_s - {1'b0, opnd_i};
      qbit_o   = ~diff_s[WIDTH];
      acc_o    = {(qbit_o ? diff_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0]),
                  acc_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU), any even WIDTH >= 4.
// Fixed latency of WIDTH+3 cycles from the accepting edge to done.
// Optional feature macro: MULDIV_FAST_ZERO_EN -- zero multiplies and divides
// by zero skip RUN/FIX and finish two cycles after start.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e               state_q;
  logic [1:0]           op_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opnd_q;
  logic                 neg_lo_q;
  logic                 neg_hi_q;
  logic                 dz_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 div_zero_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 mode_s;
  logic [2*WIDTH-1:0]   step_acc_s;
  logic                 step_qbit_s;
  logic [2*WIDTH-1:0]   acc_d;

  logic                 sgn_s;
  logic                 div_s;
  logic [WIDTH-1:0]     abs_a_s;
  logic [WIDTH-1:0]     abs_b_s;
  logic [2*WIDTH-1:0]   prep_acc_s;
  logic [WIDTH-1:0]     prep_opnd_s;
  logic                 prep_neg_lo_s;
  logic                 prep_neg_hi_s;
  logic                 prep_dz_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     fix_hi_s;
  logic [WIDTH-1:0]     fix_lo_s;

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

  assign mode_s = op_is_div(op_q) ? MODE_DIV : MODE_MUL;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .mode_i (mode_s),
    .acc_o  (step_acc_s),
    .qbit_o (step_qbit_s)
  );

  // Quotient bit enters at the bottom; it is always 0 in multiply mode.
  assign acc_d = {step_acc_s[2*WIDTH-1:1], step_acc_s[0] | step_qbit_s};

  // Operand magnitudes, result signs and initial accumulator for PREP.
  always_comb begin
    sgn_s         = op_is_signed(op_q);
    div_s         = op_is_div(op_q);
    abs_a_s       = (sgn_s && a_q[WIDTH-1]) ? -a_q : a_q;
    abs_b_s       = (sgn_s && b_q[WIDTH-1]) ? -b_q : b_q;
    prep_neg_lo_s = sgn_s & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    prep_dz_s     = div_s & (b_q == {WIDTH{1'b0}});
    if (div_s) begin
      prep_acc_s    = {{WIDTH{1'b0}}, abs_a_s};
      prep_opnd_s   = abs_b_s;
      prep_neg_hi_s = sgn_s & a_q[WIDTH-1];
    end else begin
      prep_acc_s    = {{WIDTH{1'b0}}, abs_b_s};
      prep_opnd_s   = abs_a_s;
      prep_neg_hi_s = prep_neg_lo_s;
    end
  end

  // Sign correction and divide-by-zero substitution applied in FIX.
  always_comb begin
    prod_s = neg_lo_q ? -acc_q : acc_q;
    if (dz_q) begin
      fix_hi_s = a_q;
      fix_lo_s = {WIDTH{1'b1}};
    end else if (op_is_div(op_q)) begin
      fix_hi_s = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      fix_lo_s = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end else begin
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

`ifdef MULDIV_FAST_ZERO_EN
  logic             fast_zero_s;
  logic [WIDTH-1:0] fast_hi_s;
  logic [WIDTH-1:0] fast_lo_s;

  // Early-exit detection: trivially-zero multiply or any divide by zero.
  always_comb begin
    if (op_is_div(op_q)) begin
      fast_zero_s = prep_dz_s;
    end else begin
      fast_zero_s = (a_q == {WIDTH{1'b0}}) || (b_q == {WIDTH{1'b0}});
    end
    if (prep_dz_s) begin
      fast_hi_s = a_q;
      fast_lo_s = {WIDTH{1'b1}};
    end else begin
      fast_hi_s = {WIDTH{1'b0}};
      fast_lo_s = {WIDTH{1'b0}};
    end
  end
`endif

  // Control FSM with iteration counter and registered result/status outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      op_q       <= 2'b00;
      a_q        <= {WIDTH{1'b0}};
      b_q        <= {WIDTH{1'b0}};
      acc_q      <= {(2*WIDTH){1'b0}};
      opnd_q     <= {WIDTH{1'b0}};
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dz_q       <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            busy_q  <= 1'b1;
            state_q <= ST_PREP;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_PREP: begin
          acc_q    <= prep_acc_s;
          opnd_q   <= prep_opnd_s;
          neg_lo_q <= prep_neg_lo_s;
          neg_hi_q <= prep_neg_hi_s;
          dz_q     <= prep_dz_s;
          cnt_q    <= {CNT_W{1'b0}};
`ifdef MULDIV_FAST_ZERO_EN
          if (fast_zero_s) begin
            hi_q       <= fast_hi_s;
            lo_q       <= fast_lo_s;
            div_zero_q <= prep_dz_s;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            state_q <= ST_RUN;
          end
`else
          state_q <= ST_RUN;
`endif
        end
        ST_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_FIX;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_FIX: begin
          hi_q       <= fix_hi_s;
          lo_q       <= fix_lo_s;
          div_zero_q <= dz_q;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          state_q    <= ST_DONE;
        end
        ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            busy_q  <= 1'b1;
            state_q <= ST_PREP;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table at WIDTH=32, hand sequences for
// busy-ignore, back-to-back start, mid-run reset, and one WIDTH=8 product.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_ZERO_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int LAT = 35;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    bit          zero;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  logic        start8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [7:0]  a8 = 8'h0;
  logic [7:0]  b8 = 8'h0;
  logic        busy8, done8, div_zero8;
  logic [7:0]  hi8, lo8;

  int errors = 0;
  int checks = 0;
  vec_t vecs[11];

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) u_dut (
    .CLK(clk), .RST_N(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .CLK(clk), .RST_N(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(div_zero8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge: presents one request across the next rising edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges after the accepting edge until done; checks latency and busy.
  task automatic wait_done(input int exp_lat, input string name);
    int n = 0;
    bit seen = 1'b0;
    bit busy_ok = 1'b1;
    while (!seen && n < exp_lat + 5) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1'b1;
      else if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check({name, " latency"}, 64'(n), 64'(exp_lat));
    check({name, " busy"}, {63'd0, busy_ok}, 64'd1);
    check({name, " busy at done"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [31:0] prev_hi, prev_lo;
    bit hold_ok;
    int dones;
    int n;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0, "mult_neg3x7"};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, "multu_max"};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, "div_neg7by2"};
    vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0, "div_min_by_m1"};
    vecs[4]  = '{OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1, 1'b1, "divu_by_zero"};
    vecs[5]  = '{OP_MULTU, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0, 1'b0, "multu_2x3"};
    vecs[6]  = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 1'b0, "divu_100by7"};
    vecs[7]  = '{OP_MULT,  32'h7FFFFFFF, 32'h00000002, 32'h00000000, 32'hFFFFFFFE, 1'b0, 1'b0, "mult_maxpos_x2"};
    vecs[8]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0, "div_7by_neg2"};
    vecs[9]  = '{OP_MULT,  32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0, 1'b1, "mult_0x5"};
    vecs[10] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1'b1, "div_neg7_by_zero"};

    // Reset state
    #2;
    check("reset outputs", {27'd0, busy, done, div_zero, busy8, done8, hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done((FAST && vecs[i].zero) ? 2 : LAT, vecs[i].name);
      check({vecs[i].name, " hi"}, {32'd0, hi}, {32'd0, vecs[i].hi});
      check({vecs[i].name, " lo"}, {32'd0, lo}, {32'd0, vecs[i].lo});
      check({vecs[i].name, " div_zero"}, {63'd0, div_zero}, {63'd0, vecs[i].dz});
      @(negedge clk);
      check({vecs[i].name, " done pulse"}, {63'd0, done}, 64'd0);
    end

    // Start while busy is ignored; results hold until the first done
    prev_hi = vecs[10].hi;
    prev_lo = vecs[10].lo;
    hold_ok = 1'b1;
    launch(OP_MULTU, 32'd5, 32'd6);
    n = 0;
    while (n < LAT - 1) begin
      @(negedge clk);
      n++;
      if (n == 5) begin start = 1'b1; op = OP_MULT; a = 32'd1; b = 32'd1; end
      if (n == 6) start = 1'b0;
      if (hi !== prev_hi || lo !== prev_lo || done !== 1'b0) hold_ok = 1'b0;
    end
    check("busy_ignore hold", {63'd0, hold_ok}, 64'd1);
    @(negedge clk);
    check("busy_ignore done", {63'd0, done}, 64'd1);
    check("busy_ignore lo", {32'd0, lo}, 64'd30);
    check("busy_ignore div_zero", {63'd0, div_zero}, 64'd0);
    dones = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("busy_ignore no extra done", 64'(dones), 64'd0);

    // Start accepted in the DONE cycle
    launch(OP_MULTU, 32'd4, 32'd4);
    wait_done(LAT, "chain_first");
    check("chain_first lo", {32'd0, lo}, 64'd16);
    launch(OP_MULTU, 32'd7, 32'd9);
    wait_done(LAT, "chain_second");
    check("chain_second lo", {32'd0, lo}, 64'd63);

    // Asynchronous reset during RUN
    @(negedge clk);
    launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int j = 0; j < 11; j++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset mid-run outputs", {29'd0, busy, done, div_zero, hi}, 64'd0);
    check("reset mid-run lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int j = 0; j < 45; j++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("reset mid-run no done", 64'(dones), 64'd0);

    // WIDTH=8 signed product 0x80*0x80
    start8 = 1'b1; op8 = OP_MULT; a8 = 8'h80; b8 = 8'h80;
    @(posedge clk);
    #1 start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w8 latency", 64'(n), 64'd11);
    check("w8 hi", {56'd0, hi8}, 64'h40);
    check("w8 lo", {56'd0, lo8}, 64'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
